// File: rtl/mac18_pkg.sv
// Shared constants for the 18x18 multiply-add slice.
//   P_WIDTH_*     : supported result widths (RTAX, G4, PolarFire families)
//   SHIFT_AMT     : cascade/addend arithmetic shift distance
//   AB_WIDTH      : multiplicand width
//   PROD_WIDTH    : full signed product width
package mac18_pkg;

    localparam int P_WIDTH_RTAX = 41;
    localparam int P_WIDTH_G4   = 44;
    localparam int P_WIDTH_PF   = 48;

    localparam int SHIFT_AMT    = 17;
    localparam int AB_WIDTH     = 18;
    localparam int PROD_WIDTH   = 2 * AB_WIDTH;

    function automatic bit pwidth_legal(int w);
        return (w == P_WIDTH_RTAX) || (w == P_WIDTH_G4) || (w == P_WIDTH_PF);
    endfunction

endpackage

// File: rtl/mac_pipe_reg.sv
// Optional pipeline register used for the A, B and P stages of the slice.
//   clk    : rising-edge clock
//   nGrst  : asynchronous active-low clear
//   rstn   : synchronous active-low clear, overrides en
//   en     : load enable
//   d / q  : data in / out; with BYPASS = 1 q follows d and all controls are ignored
module mac_pipe_reg #(
    parameter int W      = 18,
    parameter bit BYPASS = 1'b0
) (
    input  logic         clk,
    input  logic         nGrst,
    input  logic         rstn,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_d;
    logic [W-1:0] r_q;

    always_comb begin
        r_d = r_q;
        if (!rstn) begin
            r_d = '0;
        end else if (en) begin
            r_d = d;
        end
    end

    always_ff @(posedge clk or negedge nGrst) begin
        if (!nGrst) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign q = BYPASS ? d : r_q;

endmodule

// File: rtl/mac18x18_core.sv
// Generic model of a hard 18x18 signed multiply-add DSP slice:
//   p = addend +/- a_q * b_q, with optional A, B and P register stages.
//   clk, nGrst, rstn   : clock, async active-low clear, sync active-low clear
//   en_a, en_b, en_p   : stage load enables
//   a, b               : signed 18-bit multiplicands
//   cin, cdin          : signed local / cascade addends
//   cdsel, shftsel, sub: addend select, addend >>> 17, subtract product
//   p, cdout, ovfl     : result, cascade copy of result, signed overflow flag
module mac18x18_core
    import mac18_pkg::*;
#(
    parameter int P_WIDTH      = 44,
    parameter bit BYPASS_REG_A = 1'b0,
    parameter bit BYPASS_REG_B = 1'b0,
    parameter bit BYPASS_REG_P = 1'b0
) (
    input  logic                      clk,
    input  logic                      nGrst,
    input  logic                      rstn,
    input  logic                      en_a,
    input  logic                      en_b,
    input  logic                      en_p,
    input  logic signed [17:0]        a,
    input  logic signed [17:0]        b,
    input  logic signed [P_WIDTH-1:0] cin,
    input  logic signed [P_WIDTH-1:0] cdin,
    input  logic                      cdsel,
    input  logic                      shftsel,
    input  logic                      sub,
    output logic        [P_WIDTH-1:0] p,
    output logic        [P_WIDTH-1:0] cdout,
    output logic                      ovfl
);

    if (!pwidth_legal(P_WIDTH)) begin : g_bad_pwidth
        $error("mac18x18_core: P_WIDTH must be 41, 44 or 48");
    end

    logic signed [AB_WIDTH-1:0]   a_q;
    logic signed [AB_WIDTH-1:0]   b_q;
    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [P_WIDTH-1:0]    add0;
    logic signed [P_WIDTH-1:0]    add_sh;
    // One guard bit above P_WIDTH: the true sum always fits, so overflow is
    // simply the guard bit disagreeing with the result sign bit.
    logic signed [P_WIDTH:0]      add_x;
    logic signed [P_WIDTH:0]      prod_x;
    logic signed [P_WIDTH:0]      sum_x;
    logic                         ovfl_d;
    logic        [P_WIDTH:0]      p_stage_d;
    logic        [P_WIDTH:0]      p_stage_q;

    mac_pipe_reg #(.W(AB_WIDTH), .BYPASS(BYPASS_REG_A)) u_reg_a (
        .clk(clk), .nGrst(nGrst), .rstn(rstn), .en(en_a), .d(a), .q(a_q)
    );

    mac_pipe_reg #(.W(AB_WIDTH), .BYPASS(BYPASS_REG_B)) u_reg_b (
        .clk(clk), .nGrst(nGrst), .rstn(rstn), .en(en_b), .d(b), .q(b_q)
    );

    always_comb begin
        prod      = a_q * b_q;
        add0      = cdsel ? cdin : cin;
        add_sh    = shftsel ? (add0 >>> SHIFT_AMT) : add0;
        add_x     = {add_sh[P_WIDTH-1], add_sh};
        prod_x    = {{(P_WIDTH + 1 - PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
        sum_x     = sub ? (add_x - prod_x) : (add_x + prod_x);
        ovfl_d    = sum_x[P_WIDTH] ^ sum_x[P_WIDTH-1];
        p_stage_d = {ovfl_d, sum_x[P_WIDTH-1:0]};
    end

    // P stage carries the overflow flag alongside the result.
    mac_pipe_reg #(.W(P_WIDTH + 1), .BYPASS(BYPASS_REG_P)) u_reg_p (
        .clk(clk), .nGrst(nGrst), .rstn(rstn), .en(en_p),
        .d(p_stage_d), .q(p_stage_q)
    );

    assign p     = p_stage_q[P_WIDTH-1:0];
    assign cdout = p_stage_q[P_WIDTH-1:0];
    assign ovfl  = p_stage_q[P_WIDTH];

endmodule

// File: tb/tb_mac18x18_core.sv
module tb_mac18x18_core;

    logic               clk = 1'b0;
    logic               nGrst, rstn, en_a, en_b, en_p;
    logic signed [17:0] a, b;
    logic signed [40:0] cin, cdin;
    logic               cdsel, shftsel, sub;
    logic        [40:0] p, cdout;
    logic               ovfl;

    logic               nGrst2, rstn2, en_a2, en_b2, en_p2;
    logic signed [17:0] a2, b2;
    logic signed [43:0] cin2, cdin2;
    logic               cdsel2, shftsel2, sub2;
    logic        [43:0] p2, cdout2;
    logic               ovfl2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mac18x18_core #(.P_WIDTH(41)) dut (
        .clk(clk), .nGrst(nGrst), .rstn(rstn),
        .en_a(en_a), .en_b(en_b), .en_p(en_p),
        .a(a), .b(b), .cin(cin), .cdin(cdin),
        .cdsel(cdsel), .shftsel(shftsel), .sub(sub),
        .p(p), .cdout(cdout), .ovfl(ovfl)
    );

    mac18x18_core #(.P_WIDTH(44), .BYPASS_REG_A(1'b1), .BYPASS_REG_B(1'b1),
                    .BYPASS_REG_P(1'b1)) dut_byp (
        .clk(clk), .nGrst(nGrst2), .rstn(rstn2),
        .en_a(en_a2), .en_b(en_b2), .en_p(en_p2),
        .a(a2), .b(b2), .cin(cin2), .cdin(cdin2),
        .cdsel(cdsel2), .shftsel(shftsel2), .sub(sub2),
        .p(p2), .cdout(cdout2), .ovfl(ovfl2)
    );

    task automatic check_w(input string tag, input logic signed [47:0] obs,
                           input logic signed [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nGrst = 1'b0; rstn = 1'b1; en_a = 1'b1; en_b = 1'b1; en_p = 1'b1;
        a = 18'sd3; b = 18'sd5; cin = '0; cdin = '0;
        cdsel = 1'b0; shftsel = 1'b0; sub = 1'b0;
        nGrst2 = 1'b0; rstn2 = 1'b0; en_a2 = 1'b0; en_b2 = 1'b0; en_p2 = 1'b0;
        a2 = '0; b2 = '0; cin2 = '0; cdin2 = '0;
        cdsel2 = 1'b0; shftsel2 = 1'b0; sub2 = 1'b0;

        #1;
        check_w("reset_p", $signed(p), 48'sd0);
        check_b("reset_ovfl", ovfl, 1'b0);

        // release reset: 3*5 appears two edges later
        tick();
        nGrst = 1'b1;
        tick();
        check_w("lat_first_edge", $signed(p), 48'sd0);
        tick();
        check_w("lat_two_edges", $signed(p), 48'sd15);

        // async reset mid-cycle with loaded registers
        #2;
        nGrst = 1'b0;
        #1;
        check_w("async_clear_p", $signed(p), 48'sd0);
        check_w("async_clear_cdout", $signed(cdout), 48'sd0);
        nGrst = 1'b1;
        tick();
        check_w("flush_first_edge", $signed(p), 48'sd0);
        tick();
        check_w("flush_refill", $signed(p), 48'sd15);

        // cascade subtract; cin ignored
        cdsel = 1'b1; cdin = 41'sd100; sub = 1'b1; cin = 41'sd12345;
        a = -18'sd4; b = 18'sd7;
        tick();
        check_w("cdin_lat1_old_prod", $signed(p), 48'sd85);
        tick();
        check_w("cascade_sub", $signed(p), 48'sd128);

        // shifted addend: -2^20 >>> 17 = -8
        cdsel = 1'b0; sub = 1'b0; shftsel = 1'b1; cin = -41'sd1048576;
        a = 18'sd1; b = 18'sd1;
        tick(); tick();
        check_w("shift", $signed(p), -48'sd7);

        // A-enable hold
        shftsel = 1'b0; cin = '0; a = 18'sd5; b = 18'sd1;
        tick(); tick();
        check_w("load_5x1", $signed(p), 48'sd5);
        en_a = 1'b0; a = 18'sd9; b = 18'sd2;
        tick(); tick();
        check_w("hold_a", $signed(p), 48'sd10);

        // P enable low holds; sync reset overrides the enable
        en_a = 1'b1; en_p = 1'b0; a = 18'sd3; b = 18'sd3; cin = 41'sd7;
        tick();
        check_w("hold_p", $signed(p), 48'sd10);
        rstn = 1'b0;
        tick();
        check_w("sync_clear_p", $signed(p), 48'sd0);
        rstn = 1'b1; en_p = 1'b1; cin = '0;
        tick();
        check_w("sync_clear_ab", $signed(p), 48'sd0);
        tick();
        check_w("after_sync_clear", $signed(p), 48'sd9);

        // most negative operands: exact 2^34, no overflow
        a = -18'sd131072; b = -18'sd131072;
        tick(); tick();
        check_w("extreme_prod", $signed(p), 48'sd17179869184);
        check_b("extreme_no_ovfl", ovfl, 1'b0);

        // positive wrap
        a = 18'sd1; b = 18'sd1; cin = 41'sh0FF_FFFF_FFFF;
        tick(); tick();
        check_w("wrap_pos_p", $signed(p), -48'sd1099511627776);
        check_w("wrap_pos_cdout", $signed(cdout), -48'sd1099511627776);
        check_b("wrap_pos_ovfl", ovfl, 1'b1);

        // negative wrap via subtract
        cin = 41'sh100_0000_0000; sub = 1'b1;
        tick();
        check_w("wrap_neg_p", $signed(p), 48'sd1099511627775);
        check_b("wrap_neg_ovfl", ovfl, 1'b1);

        // fully bypassed: combinational, controls held inactive/reset
        a2 = 18'sd2; b2 = -18'sd3; cin2 = 44'sd10;
        #1;
        check_w("bypass_add", $signed(p2), 48'sd4);
        check_b("bypass_ovfl", ovfl2, 1'b0);
        cdsel2 = 1'b1; cdin2 = -44'sd50; sub2 = 1'b1;
        #1;
        check_w("bypass_cascade_sub", $signed(p2), -48'sd44);
        check_w("bypass_cdout", $signed(cdout2), -48'sd44);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
